// File: rtl/foc_sequencer_pkg.sv
// Shared types and helpers for the FOC run-time supervisor (foc_sequencer).
package foc_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CAL    = 3'd1,
      ST_ALIGN  = 3'd2,
      ST_RUN    = 3'd3,
      ST_RAMPDN = 3'd4,
      ST_FAULT  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      FC_NONE    = 2'd0,
      FC_CAL     = 2'd1,
      FC_OC      = 2'd2,
      FC_TIMEOUT = 2'd3
   } fault_t;

   localparam logic [11:0] ADC_MID = 12'd2048;

   function automatic logic [16:0] abs17(input logic signed [16:0] v);
      return (v < 0) ? 17'(-v) : 17'(v);
   endfunction

endpackage

// File: rtl/foc_sequencer_slew_limiter.sv
// Step-limited signed tracker: on each enable the output moves toward the target by at most STEP.
module slew_limiter #(
   parameter logic [15:0] STEP = 16'd64
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_clr,
   input  logic               i_en,
   input  logic signed [15:0] i_target,
   output logic signed [15:0] o_aim
);

   logic signed [15:0] r_aim;
   logic signed [16:0] w_tgt, w_cur, w_step, w_diff, w_next;

   always_comb begin
      w_tgt  = $signed({i_target[15], i_target});
      w_cur  = $signed({r_aim[15], r_aim});
      w_step = $signed({1'b0, STEP});
      w_diff = w_tgt - w_cur;
      if (w_diff > w_step)
         w_next = w_cur + w_step;
      else if (w_diff < -w_step)
         w_next = w_cur - w_step;
      else
         w_next = w_tgt;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn || i_clr)
         r_aim <= '0;
      else if (i_en)
         r_aim <= w_next[15:0];
   end

   assign o_aim = r_aim;

endmodule

// File: rtl/foc_sequencer.sv
// Supervisor in front of the FOC core: ADC offset calibration, alignment, ramped run, fault latching.
// Define FOC_SEQ_WDT_EN to add the en_idq watchdog in RUN/RAMPDN.
module foc_sequencer
   import foc_seq_pkg::*;
#(
   parameter int unsigned CAL_LOG2      = 6,
   parameter int unsigned CAL_PERIOD    = 2048,
   parameter logic [11:0] CAL_TOL       = 12'd256,
   parameter int unsigned ALIGN_TIMEOUT = 33554432,
   parameter logic [15:0] RAMP_STEP     = 16'd64,
   parameter logic [15:0] OC_LIMIT      = 16'd12000,
   parameter logic [3:0]  OC_COUNT      = 4'd3,
   parameter int unsigned WDT_CYCLES    = 8192
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic               i_fault_clr,
   input  logic signed [15:0] i_id_target,
   input  logic signed [15:0] i_iq_target,
   input  logic               i_core_sn_adc,
   output logic               o_sn_adc,
   input  logic               i_en_adc,
   input  logic [11:0]        i_adc_a,
   input  logic [11:0]        i_adc_b,
   input  logic [11:0]        i_adc_c,
   output logic               o_cor_en_adc,
   output logic [11:0]        o_cor_a,
   output logic [11:0]        o_cor_b,
   output logic [11:0]        o_cor_c,
   output logic               o_core_rstn,
   input  logic               i_core_init_done,
   input  logic               i_en_idq,
   input  logic signed [15:0] i_id,
   input  logic signed [15:0] i_iq,
   output logic signed [15:0] o_id_aim,
   output logic signed [15:0] o_iq_aim,
   output logic [2:0]         o_state,
   output logic [1:0]         o_fault_code,
   output logic [11:0]        o_offset_a,
   output logic [11:0]        o_offset_b,
   output logic [11:0]        o_offset_c
);

   localparam logic [10:0] NSAMP_M1 = 11'((1 << CAL_LOG2) - 1);

   state_t      r_state;
   fault_t      r_fault;
   logic [31:0] r_cnt;
   logic        r_cal_pulse;
   logic [10:0] r_nsamp;
   logic [3:0]  r_oc;
   logic [21:0] r_acc [3];
   logic [11:0] r_off [3];
   logic [11:0] r_cor [3];
   logic        r_cor_en;

   logic [11:0]        w_adc     [3];
   logic [21:0]        w_sum     [3];
   logic [11:0]        w_off_new [3];
   logic signed [13:0] w_cdiff   [3];
   logic [11:0]        w_cor     [3];
   logic               w_off_bad;
   logic               w_active, w_over, w_oc_trip, w_wdt_trip, w_fault_now;
   logic [3:0]         w_oc_next;
   logic               w_ramp_en, w_ramp_clr;
   logic signed [15:0] w_id_tgt, w_iq_tgt;

   assign w_adc[0] = i_adc_a;
   assign w_adc[1] = i_adc_b;
   assign w_adc[2] = i_adc_c;

   always_comb begin
      w_off_bad = 1'b0;
      for (int unsigned k = 0; k < 3; k++) begin
         w_sum[k]     = r_acc[k] + 22'(w_adc[k]);
         w_off_new[k] = w_sum[k][CAL_LOG2 +: 12];
         if (abs17(17'(w_off_new[k]) - 17'(ADC_MID)) > 17'(CAL_TOL))
            w_off_bad = 1'b1;
         w_cdiff[k] = $signed({2'b00, w_adc[k]}) - $signed({2'b00, r_off[k]}) + 14'sd2048;
         if (w_cdiff[k] < 0)
            w_cor[k] = '0;
         else if (w_cdiff[k] > 14'sd4095)
            w_cor[k] = '1;
         else
            w_cor[k] = w_cdiff[k][11:0];
      end
   end

   assign w_active  = (r_state == ST_RUN) || (r_state == ST_RAMPDN);
   assign w_over    = (abs17($signed({i_id[15], i_id})) > 17'(OC_LIMIT)) ||
                      (abs17($signed({i_iq[15], i_iq})) > 17'(OC_LIMIT));
   assign w_oc_next = r_oc + 4'd1;
   assign w_oc_trip = i_en_idq && w_over && (w_oc_next >= OC_COUNT);

`ifdef FOC_SEQ_WDT_EN
   logic [31:0] r_wdt;

   always_ff @(posedge i_clk) begin
      if (!i_rstn || !w_active || i_en_idq)
         r_wdt <= '0;
      else
         r_wdt <= r_wdt + 32'd1;
   end

   assign w_wdt_trip = !i_en_idq && (r_wdt >= 32'(WDT_CYCLES - 1));
`else
   assign w_wdt_trip = 1'b0;
`endif

   assign w_fault_now = w_active && (w_oc_trip || w_wdt_trip);

   // A fault in the same cycle as en_idq suppresses the ramp step and clears the aims.
   assign w_ramp_en  = w_active && i_en_idq && !w_fault_now;
   assign w_ramp_clr = !w_active || w_fault_now;
   assign w_id_tgt   = (r_state == ST_RUN) ? i_id_target : '0;
   assign w_iq_tgt   = (r_state == ST_RUN) ? i_iq_target : '0;

   slew_limiter #(.STEP(RAMP_STEP)) u_slew_id (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(w_ramp_clr), .i_en(w_ramp_en),
      .i_target(w_id_tgt), .o_aim(o_id_aim)
   );

   slew_limiter #(.STEP(RAMP_STEP)) u_slew_iq (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(w_ramp_clr), .i_en(w_ramp_en),
      .i_target(w_iq_tgt), .o_aim(o_iq_aim)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state     <= ST_IDLE;
         r_fault     <= FC_NONE;
         r_cnt       <= '0;
         r_cal_pulse <= 1'b0;
         r_nsamp     <= '0;
         r_oc        <= '0;
         r_cor_en    <= 1'b0;
         for (int unsigned k = 0; k < 3; k++) begin
            r_acc[k] <= '0;
            r_off[k] <= ADC_MID;
            r_cor[k] <= '0;
         end
      end else begin
         r_cor_en <= i_en_adc;
         for (int unsigned k = 0; k < 3; k++)
            r_cor[k] <= w_cor[k];

         case (r_state)
            ST_IDLE: begin
               r_cal_pulse <= 1'b0;
               r_oc        <= '0;
               if (i_start && !i_stop) begin
                  r_state     <= ST_CAL;
                  r_cnt       <= '0;
                  r_cal_pulse <= 1'b1;
                  r_nsamp     <= '0;
                  for (int unsigned k = 0; k < 3; k++)
                     r_acc[k] <= '0;
               end
            end
            ST_CAL: begin
               if (i_stop) begin
                  r_state     <= ST_IDLE;
                  r_cal_pulse <= 1'b0;
               end else begin
                  if (r_cnt == 32'(CAL_PERIOD - 1)) begin
                     r_cnt       <= '0;
                     r_cal_pulse <= 1'b1;
                  end else begin
                     r_cnt       <= r_cnt + 32'd1;
                     r_cal_pulse <= 1'b0;
                  end
                  if (i_en_adc) begin
                     if (r_nsamp == NSAMP_M1) begin
                        for (int unsigned k = 0; k < 3; k++)
                           r_off[k] <= w_off_new[k];
                        r_cal_pulse <= 1'b0;
                        r_cnt       <= '0;
                        if (w_off_bad) begin
                           r_state <= ST_FAULT;
                           r_fault <= FC_CAL;
                        end else begin
                           r_state <= ST_ALIGN;
                        end
                     end else begin
                        for (int unsigned k = 0; k < 3; k++)
                           r_acc[k] <= w_sum[k];
                        r_nsamp <= r_nsamp + 11'd1;
                     end
                  end
               end
            end
            ST_ALIGN: begin
               r_cnt <= r_cnt + 32'd1;
               if (i_stop) begin
                  r_state <= ST_IDLE;
               end else if (i_core_init_done) begin
                  r_state <= ST_RUN;
                  r_oc    <= '0;
               end else if (r_cnt >= 32'(ALIGN_TIMEOUT - 1)) begin
                  r_state <= ST_FAULT;
                  r_fault <= FC_TIMEOUT;
               end
            end
            ST_RUN, ST_RAMPDN: begin
               if (i_en_idq)
                  r_oc <= w_over ? w_oc_next : '0;
               if (w_fault_now) begin
                  r_state <= ST_FAULT;
                  r_fault <= w_oc_trip ? FC_OC : FC_TIMEOUT;
               end else if (r_state == ST_RUN && i_stop) begin
                  r_state <= ST_RAMPDN;
               end else if (r_state == ST_RAMPDN && o_id_aim == '0 && o_iq_aim == '0) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_FAULT: begin
               r_oc <= '0;
               if (i_fault_clr) begin
                  r_state <= ST_IDLE;
                  r_fault <= FC_NONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      o_sn_adc = 1'b0;
      case (r_state)
         ST_CAL:                     o_sn_adc = r_cal_pulse;
         ST_ALIGN, ST_RUN, ST_RAMPDN: o_sn_adc = i_core_sn_adc;
         default:                    o_sn_adc = 1'b0;
      endcase
   end

   assign o_core_rstn  = (r_state == ST_ALIGN) || w_active;
   assign o_state      = r_state;
   assign o_fault_code = r_fault;
   assign o_cor_en_adc = r_cor_en;
   assign o_cor_a      = r_cor[0];
   assign o_cor_b      = r_cor[1];
   assign o_cor_c      = r_cor[2];
   assign o_offset_a   = r_off[0];
   assign o_offset_b   = r_off[1];
   assign o_offset_c   = r_off[2];

endmodule

// File: tb/tb_foc_sequencer.sv
// Directed self-checking bench for foc_sequencer; watchdog case runs only with FOC_SEQ_WDT_EN defined.
module tb_foc_sequencer;

   localparam int unsigned T_CAL_PERIOD = 8;
   localparam int unsigned T_ALIGN_TO   = 50;
   localparam int unsigned T_WDT        = 40;

   logic               clk = 1'b0;
   logic               rstn, start, stop, fault_clr;
   logic signed [15:0] id_target, iq_target;
   logic               core_sn_adc, sn_adc, en_adc;
   logic [11:0]        adc_a, adc_b, adc_c;
   logic               cor_en_adc;
   logic [11:0]        cor_a, cor_b, cor_c;
   logic               core_rstn, core_init_done, en_idq;
   logic signed [15:0] id, iq, id_aim, iq_aim;
   logic [2:0]         state;
   logic [1:0]         fault_code;
   logic [11:0]        offset_a, offset_b, offset_c;

   int n_checks = 0;
   int n_fail   = 0;
   int np, first, last, n;

   always #5 clk = ~clk;

   foc_sequencer #(
      .CAL_LOG2(2), .CAL_PERIOD(T_CAL_PERIOD), .CAL_TOL(12'd256),
      .ALIGN_TIMEOUT(T_ALIGN_TO), .RAMP_STEP(16'd64), .OC_LIMIT(16'd12000),
      .OC_COUNT(4'd3), .WDT_CYCLES(T_WDT)
   ) dut (
      .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_stop(stop), .i_fault_clr(fault_clr),
      .i_id_target(id_target), .i_iq_target(iq_target), .i_core_sn_adc(core_sn_adc),
      .o_sn_adc(sn_adc), .i_en_adc(en_adc), .i_adc_a(adc_a), .i_adc_b(adc_b), .i_adc_c(adc_c),
      .o_cor_en_adc(cor_en_adc), .o_cor_a(cor_a), .o_cor_b(cor_b), .o_cor_c(cor_c),
      .o_core_rstn(core_rstn), .i_core_init_done(core_init_done), .i_en_idq(en_idq),
      .i_id(id), .i_iq(iq), .o_id_aim(id_aim), .o_iq_aim(iq_aim), .o_state(state),
      .o_fault_code(fault_code), .o_offset_a(offset_a), .o_offset_b(offset_b), .o_offset_c(offset_c)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Starts calibration and answers every sn_adc pulse with one en_adc cycle.
   task automatic do_cal(output int pulses, output int p_first, output int p_last);
      pulses = 0; p_first = -1; p_last = -1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (state != 3'd1) break;
         if (sn_adc) begin
            if (pulses == 0) p_first = c;
            p_last = c;
            pulses++;
         end
         en_adc = sn_adc;
         tick();
      end
      en_adc = 1'b0;
   endtask

   task automatic idq(input logic signed [15:0] id_v, input logic signed [15:0] iq_v);
      id = id_v; iq = iq_v; en_idq = 1'b1;
      tick();
      en_idq = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; stop = 1'b0; fault_clr = 1'b0;
      id_target = '0; iq_target = '0; core_sn_adc = 1'b0; en_adc = 1'b0;
      adc_a = 12'd0; adc_b = 12'd0; adc_c = 12'd0;
      core_init_done = 1'b0; en_idq = 1'b0; id = '0; iq = '0;

      // Reset
      repeat (3) tick();
      rstn = 1'b1;
      tick();
      chk("rst_state", 32'(state), 0);
      chk("rst_core_rstn", 32'(core_rstn), 0);
      chk("rst_sn_adc", 32'(sn_adc), 0);
      chk("rst_cor_en", 32'(cor_en_adc), 0);
      chk("rst_cor_a", 32'(cor_a), 0);
      chk("rst_iq_aim", 32'(iq_aim), 0);
      chk("rst_fault", 32'(fault_code), 0);
      chk("rst_offset_b", 32'(offset_b), 2048);

      // Good calibration
      adc_a = 12'd2100; adc_b = 12'd2000; adc_c = 12'd2048;
      do_cal(np, first, last);
      chk("cal_pulses", 32'(np), 4);
      chk("cal_first", 32'(first), 0);
      chk("cal_spacing", 32'(last - first), 3 * T_CAL_PERIOD);
      chk("cal_off_a", 32'(offset_a), 2100);
      chk("cal_off_b", 32'(offset_b), 2000);
      chk("cal_off_c", 32'(offset_c), 2048);
      chk("cal_state_align", 32'(state), 2);
      chk("align_core_rstn", 32'(core_rstn), 1);

      // Correction path incl. both clamp edges
      en_adc = 1'b1; adc_a = 12'd2100; adc_b = 12'd4095; adc_c = 12'd100;
      tick();
      chk("cor_en", 32'(cor_en_adc), 1);
      chk("cor_a_mid", 32'(cor_a), 2048);
      chk("cor_b_hiclamp", 32'(cor_b), 4095);
      chk("cor_c", 32'(cor_c), 100);
      en_adc = 1'b0; adc_a = 12'd0;
      tick();
      chk("cor_en_off", 32'(cor_en_adc), 0);
      chk("cor_a_loclamp", 32'(cor_a), 0);

      // Alignment done -> RUN, ramp up
      core_init_done = 1'b1;
      tick();
      core_init_done = 1'b0;
      chk("run_state", 32'(state), 3);
      chk("run_iq_aim0", 32'(iq_aim), 0);
      iq_target = 16'sd200;
      idq(0, 0); chk("ramp_up1", 32'(iq_aim), 64);
      tick();
      idq(0, 0); chk("ramp_up2", 32'(iq_aim), 128);
      idq(0, 0); chk("ramp_up3", 32'(iq_aim), 192);
      idq(0, 0); chk("ramp_up4", 32'(iq_aim), 200);
      chk("ramp_id_aim", 32'(id_aim), 0);

      // Stop -> ramp down to IDLE
      stop = 1'b1;
      tick();
      chk("rampdn_state", 32'(state), 4);
      idq(0, 0); chk("ramp_dn1", 32'(iq_aim), 136);
      idq(0, 0); chk("ramp_dn2", 32'(iq_aim), 72);
      idq(0, 0); chk("ramp_dn3", 32'(iq_aim), 8);
      idq(0, 0); chk("ramp_dn4", 32'(iq_aim), 0);
      tick();
      chk("rampdn_idle", 32'(state), 0);
      start = 1'b1;
      tick();
      chk("stop_prio_idle", 32'(state), 0);
      start = 1'b0; stop = 1'b0;

      // Calibration offset out of tolerance
      adc_a = 12'd2500; adc_b = 12'd2048; adc_c = 12'd2048;
      do_cal(np, first, last);
      chk("calbad_state", 32'(state), 5);
      chk("calbad_code", 32'(fault_code), 1);
      chk("calbad_core_rstn", 32'(core_rstn), 0);
      chk("calbad_off_a", 32'(offset_a), 2500);
      core_sn_adc = 1'b1;
      #1 chk("fault_sn_adc", 32'(sn_adc), 0);
      core_sn_adc = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("fault_ignores_start", 32'(state), 5);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      chk("fclr_state", 32'(state), 0);
      chk("fclr_code", 32'(fault_code), 0);

      // Stop during calibration keeps old offsets
      adc_a = 12'd2300;
      start = 1'b1;
      tick();
      start = 1'b0; en_adc = 1'b1;
      tick();
      en_adc = 1'b0; stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("calstop_state", 32'(state), 0);
      chk("calstop_off_a", 32'(offset_a), 2500);

      // Tolerance boundary (exactly +/-256) passes, then alignment timeout
      adc_a = 12'd2304; adc_b = 12'd1792; adc_c = 12'd2048;
      do_cal(np, first, last);
      chk("calbnd_state", 32'(state), 2);
      chk("calbnd_off_b", 32'(offset_b), 1792);
      core_sn_adc = 1'b1;
      #1 chk("align_sn_pass", 32'(sn_adc), 1);
      core_sn_adc = 1'b0;
      n = 0;
      while (state != 3'd5 && n < 200) begin
         tick();
         n++;
      end
      chk("align_to_cycles", 32'(n), T_ALIGN_TO);
      chk("align_to_code", 32'(fault_code), 3);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;

      // Overcurrent: interrupted runs do not trip, three consecutive do
      adc_a = 12'd2048; adc_b = 12'd2048; adc_c = 12'd2048;
      do_cal(np, first, last);
      core_init_done = 1'b1;
      tick();
      core_init_done = 1'b0;
      chk("oc_run_state", 32'(state), 3);
      idq(0, 16'sd12001);
      idq(16'sd12001, 0);
      idq(0, 16'sd12000);
      idq(0, 16'sd12001);
      idq(0, -16'sd12001);
      chk("oc_no_trip1", 32'(state), 3);
      idq(-16'sd12000, 0);
      idq(0, 16'sd12001);
      idq(-16'sd32768, 0);
      chk("oc_no_trip2", 32'(state), 3);
      chk("oc_aim_before", 32'(iq_aim), 200);
      idq(0, -16'sd12001);
      chk("oc_state", 32'(state), 5);
      chk("oc_code", 32'(fault_code), 2);
      chk("oc_aim_clr", 32'(iq_aim), 0);
      chk("oc_core_rstn", 32'(core_rstn), 0);
      id = '0; iq = '0;
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;

`ifdef FOC_SEQ_WDT_EN
      // Watchdog: no en_idq in RUN
      do_cal(np, first, last);
      core_init_done = 1'b1;
      tick();
      core_init_done = 1'b0;
      n = 0;
      while (state != 3'd5 && n < 200) begin
         tick();
         n++;
      end
      chk("wdt_cycles", 32'(n), T_WDT);
      chk("wdt_code", 32'(fault_code), 3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/foc_sequencer.md
Name: foc_sequencer

Overview:
- Run-time supervisor placed in front of the FOC current-loop core.
- Calibrates phase-current ADC offsets with the bridge disabled, then releases the core from reset and waits for rotor alignment to finish.
- Slew-limits the d/q current targets while running, and latches faults (bad offset, overcurrent, alignment timeout, watchdog) that force the core back into reset.

Parameters:
CAL_LOG2, 6, log2 of ADC samples averaged per channel during calibration (1..10)
CAL_PERIOD, 2048, clk cycles between calibration ADC triggers
CAL_TOL, 12'd256, max allowed |offset - 2048|
ALIGN_TIMEOUT, 33554432, max clk cycles waiting for core_init_done
RAMP_STEP, 16'd64, max change of id_aim/iq_aim per en_idq pulse
OC_LIMIT, 16'd12000, overcurrent threshold on |id| and |iq|
OC_COUNT, 4'd3, consecutive over-limit en_idq pulses that trigger a fault
WDT_CYCLES, 8192, max clk cycles between en_idq pulses in RUN

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
start  in  1  level; leave IDLE and begin the sequence
stop  in  1  level; ramp down and return to IDLE
fault_clr  in  1  pulse; exit FAULT to IDLE
id_target, iq_target  in  16 signed  requested d/q currents
core_sn_adc  in  1  ADC trigger from the FOC core
sn_adc  out  1  ADC trigger to the external ADC
en_adc  in  1  ADC result valid
adc_a, adc_b, adc_c  in  12  raw ADC codes
cor_en_adc  out  1  corrected result valid, to the core
cor_a, cor_b, cor_c  out  12  offset-corrected codes, to the core
core_rstn  out  1  active-low reset driven into the FOC core
core_init_done  in  1  core alignment finished
en_idq  in  1  new id/iq available
id, iq  in  16 signed  measured d/q currents
id_aim, iq_aim  out  16 signed  ramped targets, to the core
state  out  3  current FSM state
fault_code  out  2  0 none, 1 calibration, 2 overcurrent, 3 timeout/watchdog
offset_a, offset_b, offset_c  out  12  calibrated offsets

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, core_rstn=0, sn_adc=0, cor_en_adc=0, cor_*=0, id_aim=iq_aim=0, fault_code=0, offset_*=12'd2048, all counters and accumulators 0. Reset applied mid-operation aborts any state the same way.
- FSM states: IDLE=0, CAL=1, ALIGN=2, RUN=3, RAMPDN=4, FAULT=5.
- IDLE: core_rstn=0. start=1 and stop=0 -> CAL; stop has priority when both are high.
- CAL: core_rstn=0.
  - A one-cycle sn_adc pulse fires every CAL_PERIOD cycles, the first one on the cycle after entry.
  - Each en_adc adds adc_* into 22-bit accumulators.
  - After 2^CAL_LOG2 samples: offset_* = acc >> CAL_LOG2.
  - If any |offset - 2048| > CAL_TOL -> FAULT with code 1; otherwise -> ALIGN.
  - stop during CAL -> IDLE; offsets stay at their previous values.
- ALIGN: core_rstn=1 and the cycle counter restarts.
  - core_init_done=1 -> RUN with id_aim=iq_aim=0.
  - Counter reaching ALIGN_TIMEOUT -> FAULT with code 3.
  - stop -> IDLE.
- RUN: core_rstn=1. On each en_idq, each aim moves toward its target by min(|target-aim|, RAMP_STEP), computed in 17-bit signed arithmetic; the new value is visible on the next cycle. stop -> RAMPDN.
- RAMPDN: same ramp logic with targets forced to 0. When both aims are 0 -> IDLE.
- Overcurrent (RUN and RAMPDN):
  - Magnitudes are taken in 17 bits, so -32768 maps to 32768.
  - On each en_idq with |id|>OC_LIMIT or |iq|>OC_LIMIT, a 4-bit counter increments; otherwise it clears.
  - Counter reaching OC_COUNT -> FAULT with code 2.
  - Fault detection takes priority over stop and over the ramp update.
- FAULT: core_rstn=0, aims=0, fault_code held. fault_clr -> IDLE and fault_code=0. start is ignored.
- sn_adc = calibration pulse in CAL, core_sn_adc in ALIGN/RUN/RAMPDN, 0 otherwise.
- Correction path (every state), 1-cycle latency:
  - cor_en_adc is en_adc registered.
  - cor_x = clamp(adc_x - offset_x + 2048, 0, 4095), computed in 14-bit signed arithmetic.

Optional Feature:
- Macro FOC_SEQ_WDT_EN.
- Defined: in RUN/RAMPDN a counter restarts on every en_idq; reaching WDT_CYCLES without an en_idq -> FAULT with code 3.
- Undefined: no watchdog logic; code 3 arises only from the alignment timeout.

Decomposition:
- Package foc_seq_pkg holds:
  - state enum (3-bit);
  - fault-code enum (2-bit);
  - constant ADC_MID=12'd2048;
  - 17-bit abs helper function.
- Sub-module slew_limiter (step-limited signed tracker, update on enable, synchronous clear) is instantiated twice, once for id and once for iq.

Test Plan:
1. rstn low 3 cycles, then high -> all outputs at reset values, state=0, core_rstn=0.
2. start, ADC constant a=2100, b=2000, c=2048 with CAL_LOG2=2 -> 4 sn_adc pulses CAL_PERIOD apart, offsets 2100/2000/2048, state=ALIGN; then raw a=2100 -> cor_a=2048 one cycle after en_adc.
3. Calibration with adc_a=2500 (CAL_TOL=256) -> state=FAULT, fault_code=1, core_rstn=0; fault_clr -> IDLE, fault_code=0.
4. RUN, iq_target=200, RAMP_STEP=64 -> iq_aim 64, 128, 192, 200 over 4 en_idq pulses; stop -> 136, 72, 8, 0, then IDLE.
5. RUN, iq=12001 on 3 consecutive en_idq (OC_COUNT=3) -> FAULT, code 2; with 2 over-limit pulses, 1 normal, then 2 over-limit -> no fault.
6. ALIGN with core_init_done held low for ALIGN_TIMEOUT -> FAULT, code 3; with FOC_SEQ_WDT_EN defined, en_idq stopping in RUN -> FAULT, code 3 after WDT_CYCLES.
